// File: rtl/mvau_weight_mem_rt_if.sv
// Load-stream, read-request and weight-output signals of the runtime-loadable MVAU weight memory.
// The master side feeds weights and issues reads; the slave side is the memory.
interface mvau_weight_mem_rt_if #(
    parameter int SIMD         = 2,
    parameter int TW           = 1,
    parameter int PE           = 2,
    parameter int WMEM_ADDR_BW = 4
);
    logic                      load_start;
    logic                      s_wload_tvalid;
    logic                      s_wload_tready;
    logic [SIMD*TW-1:0]        s_wload_tdata;
    logic                      rd_en;
    logic [WMEM_ADDR_BW-1:0]   rd_addr;
    logic [PE*SIMD*TW-1:0]     wmem_out;
    logic                      wmem_valid;
    logic                      wmem_rdy;
    logic                      load_done;

    modport master (
        output load_start, s_wload_tvalid, s_wload_tdata, rd_en, rd_addr,
        input  s_wload_tready, wmem_out, wmem_valid, wmem_rdy, load_done
    );

    modport slave (
        input  load_start, s_wload_tvalid, s_wload_tdata, rd_en, rd_addr,
        output s_wload_tready, wmem_out, wmem_valid, wmem_rdy, load_done
    );
endinterface

// File: rtl/mvau_weight_mem_rt.sv
// Multi-PE weight memory filled at run time from a stream, read out as one word per PE per address
// with a registered latency of RD_LAT (1 or 2) cycles and an accompanying valid flag.
module mvau_weight_mem_rt #(
    parameter int SIMD         = 2,
    parameter int TW           = 1,
    parameter int PE           = 2,
    parameter int WMEM_DEPTH   = 4,
    parameter int WMEM_ADDR_BW = 4,
    parameter int RD_LAT       = 1
) (
    input logic                 aclk,
    input logic                 aresetn,
    mvau_weight_mem_rt_if.slave wif
);
    localparam int W   = SIMD * TW;
    localparam int PIW = (PE > 1) ? $clog2(PE) : 1;
    localparam int AIW = (WMEM_DEPTH > 1) ? $clog2(WMEM_DEPTH) : 1;
    localparam logic [PIW-1:0]          LAST_PE   = PIW'(PE - 1);
    localparam logic [WMEM_ADDR_BW-1:0] LAST_ADDR = WMEM_ADDR_BW'(WMEM_DEPTH - 1);
    localparam logic [WMEM_ADDR_BW:0]   DEPTH_EXT = (WMEM_ADDR_BW + 1)'(WMEM_DEPTH);

    typedef enum logic [1:0] {EMPTY, LOAD, READY} state_t;

    state_t                  state;
    logic [PIW-1:0]          pe_cnt;
    logic [WMEM_ADDR_BW-1:0] addr_cnt;
    logic                    tready_r;
    logic                    rdy_r;
    logic                    done_r;
    logic                    wr_en;
    logic                    rd_acc;
    logic                    rd_in_range;
    logic [AIW-1:0]          wr_idx;
    logic [AIW-1:0]          rd_idx;
    logic                    vld_p0;
    logic [PE*W-1:0]         data_p0;

    // tready_r/rdy_r mirror the LOAD/READY states, so they double as the write and read gates
    assign wr_en       = wif.s_wload_tvalid & tready_r;
    assign rd_acc      = wif.rd_en & rdy_r;
    assign wr_idx      = addr_cnt[AIW-1:0];
    assign rd_idx      = wif.rd_addr[AIW-1:0];
    assign rd_in_range = ({1'b0, wif.rd_addr} < DEPTH_EXT);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state    <= EMPTY;
            pe_cnt   <= '0;
            addr_cnt <= '0;
            tready_r <= 1'b0;
            rdy_r    <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                EMPTY, READY: begin
                    if (wif.load_start) begin
                        state    <= LOAD;
                        pe_cnt   <= '0;
                        addr_cnt <= '0;
                        tready_r <= 1'b1;
                        rdy_r    <= 1'b0;
                    end
                end
                LOAD: begin
                    // Address-major fill: all PE banks for one address before advancing the address
                    if (wr_en) begin
                        if (pe_cnt == LAST_PE) begin
                            pe_cnt <= '0;
                            if (addr_cnt == LAST_ADDR) begin
                                state    <= READY;
                                addr_cnt <= '0;
                                tready_r <= 1'b0;
                                rdy_r    <= 1'b1;
                                done_r   <= 1'b1;
                            end else begin
                                addr_cnt <= addr_cnt + 1'b1;
                            end
                        end else begin
                            pe_cnt <= pe_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= EMPTY;
                    tready_r <= 1'b0;
                    rdy_r    <= 1'b0;
                end
            endcase
        end
    end

    // Stage p0: per-bank memory read register
    for (genvar g = 0; g < PE; g++) begin : g_bank
        (* ram_style = "auto" *) logic [W-1:0] mem [WMEM_DEPTH];
        logic [W-1:0] rd_p0;

        always_ff @(posedge aclk) begin
            if (wr_en && (pe_cnt == PIW'(g))) begin
                mem[wr_idx] <= wif.s_wload_tdata;
            end
        end

        always_ff @(posedge aclk) begin
            if (!aresetn) begin
                rd_p0 <= '0;
            end else if (rd_acc) begin
                rd_p0 <= rd_in_range ? mem[rd_idx] : '0;
            end
        end

        assign data_p0[g*W +: W] = rd_p0;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= rd_acc;
        end
    end

    // Stage p1: optional extra output register for RD_LAT = 2
    if (RD_LAT == 2) begin : g_lat2
        logic            vld_p1;
        logic [PE*W-1:0] data_p1;

        always_ff @(posedge aclk) begin
            if (!aresetn) begin
                vld_p1  <= 1'b0;
                data_p1 <= '0;
            end else begin
                vld_p1 <= vld_p0;
                if (vld_p0) begin
                    data_p1 <= data_p0;
                end
            end
        end

        assign wif.wmem_valid = vld_p1;
        assign wif.wmem_out   = data_p1;
    end else begin : g_lat1
        assign wif.wmem_valid = vld_p0;
        assign wif.wmem_out   = data_p0;
    end

    assign wif.s_wload_tready = tready_r;
    assign wif.wmem_rdy       = rdy_r;
    assign wif.load_done      = done_r;
endmodule

// File: tb/tb_mvau_weight_mem_rt.sv
// Bench for mvau_weight_mem_rt: an RD_LAT=1 and an RD_LAT=2 instance share one stimulus stream and
// are compared against a bank/address array model filled in address-major beat order.
module tb_mvau_weight_mem_rt;
    localparam int SIMD  = 2;
    localparam int TW    = 4;
    localparam int PE    = 2;
    localparam int DEPTH = 4;
    localparam int ABW   = 4;
    localparam int W     = SIMD * TW;
    localparam int OW    = PE * W;
    localparam int NB    = PE * DEPTH;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    mvau_weight_mem_rt_if #(.SIMD(SIMD), .TW(TW), .PE(PE), .WMEM_ADDR_BW(ABW)) w1 ();
    mvau_weight_mem_rt_if #(.SIMD(SIMD), .TW(TW), .PE(PE), .WMEM_ADDR_BW(ABW)) w2 ();

    assign w2.load_start     = w1.load_start;
    assign w2.s_wload_tvalid = w1.s_wload_tvalid;
    assign w2.s_wload_tdata  = w1.s_wload_tdata;
    assign w2.rd_en          = w1.rd_en;
    assign w2.rd_addr        = w1.rd_addr;

    mvau_weight_mem_rt #(.SIMD(SIMD), .TW(TW), .PE(PE), .WMEM_DEPTH(DEPTH),
                         .WMEM_ADDR_BW(ABW), .RD_LAT(1)) dut1 (
        .aclk    (aclk),
        .aresetn (aresetn),
        .wif     (w1)
    );

    mvau_weight_mem_rt #(.SIMD(SIMD), .TW(TW), .PE(PE), .WMEM_DEPTH(DEPTH),
                         .WMEM_ADDR_BW(ABW), .RD_LAT(2)) dut2 (
        .aclk    (aclk),
        .aresetn (aresetn),
        .wif     (w2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] ref_mem [PE][DEPTH];

    function automatic logic [OW-1:0] ref_read(input int a);
        logic [OW-1:0] r;
        r = '0;
        if (a < DEPTH) begin
            for (int p = 0; p < PE; p++) r[p*W +: W] = ref_mem[p][a];
        end
        return r;
    endfunction

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_inputs;
        w1.load_start     = 1'b0;
        w1.s_wload_tvalid = 1'b0;
        w1.s_wload_tdata  = '0;
        w1.rd_en          = 1'b0;
        w1.rd_addr        = '0;
    endtask

    // Stimulus only: mode 0 = beat k carries k, no gaps; 1 = beat k carries k, valid every other cycle;
    // 2 = random data with random gaps. Reports handshakes seen, whether tready rose right after
    // load_start, and cycles from the last handshake to load_done (-1 if never seen).
    task automatic run_load(input int mode, input int n_beats, input bit restart_mid,
                            output int hs, output bit tr_first, output int lag);
        int cyc;
        int last_hs_cyc;
        bit ready_now;
        logic [W-1:0] data;
        cyc = 0;
        last_hs_cyc = -1;
        hs = 0;
        lag = -1;
        w1.load_start = 1'b1;
        tick();
        w1.load_start = 1'b0;
        tr_first = w1.s_wload_tready;
        while (cyc < 200 && lag < 0 && !(n_beats < NB && hs >= n_beats)) begin
            w1.load_start = restart_mid && (hs == 3);
            if (hs < n_beats) begin
                case (mode)
                    0:       w1.s_wload_tvalid = 1'b1;
                    1:       w1.s_wload_tvalid = (cyc % 2 == 0);
                    default: w1.s_wload_tvalid = 1'($urandom_range(0, 1));
                endcase
                data = (mode == 2) ? W'($urandom) : W'(hs);
            end else begin
                w1.s_wload_tvalid = 1'b0;
                data = W'($urandom);
            end
            w1.s_wload_tdata = data;
            ready_now = w1.s_wload_tready;
            tick();
            if (w1.s_wload_tvalid && ready_now) begin
                ref_mem[hs % PE][hs / PE] = data;
                hs++;
                last_hs_cyc = cyc;
            end
            if (w1.load_done) lag = cyc - last_hs_cyc;
            cyc++;
        end
        idle_inputs();
    endtask

    task automatic test_reset;
        aresetn = 1'b0;
        idle_inputs();
        tick();
        tick();
        n_tests++;
        if ({w1.wmem_out, w1.wmem_valid, w1.wmem_rdy, w1.load_done, w1.s_wload_tready} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_lat1: got out=%h vld=%b rdy=%b done=%b tready=%b, required all zero",
                     w1.wmem_out, w1.wmem_valid, w1.wmem_rdy, w1.load_done, w1.s_wload_tready);
        end
        n_tests++;
        if ({w2.wmem_out, w2.wmem_valid, w2.wmem_rdy, w2.load_done, w2.s_wload_tready} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_lat2: got out=%h vld=%b rdy=%b done=%b tready=%b, required all zero",
                     w2.wmem_out, w2.wmem_valid, w2.wmem_rdy, w2.load_done, w2.s_wload_tready);
        end
        aresetn = 1'b1;
        tick();
        n_tests++;
        if ({w1.wmem_rdy, w1.s_wload_tready, w1.load_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL empty_after_reset: got rdy/tready/done=%b, required 000",
                     {w1.wmem_rdy, w1.s_wload_tready, w1.load_done});
        end
    endtask

    task automatic test_full_load;
        int hs;
        int lag;
        bit trf;
        run_load(0, NB, 1'b0, hs, trf, lag);
        n_tests++;
        if (trf !== 1'b1) begin
            n_fail++;
            $display("FAIL tready_after_start: got %b, required 1", trf);
        end
        n_tests++;
        if (hs != NB || lag != 0) begin
            n_fail++;
            $display("FAIL full_load_done: got handshakes=%0d lag=%0d, required %0d and 0", hs, lag, NB);
        end
        n_tests++;
        if ({w1.wmem_rdy, w1.s_wload_tready} !== 2'b10) begin
            n_fail++;
            $display("FAIL ready_state: got rdy/tready=%b, required 10", {w1.wmem_rdy, w1.s_wload_tready});
        end
        tick();
        n_tests++;
        if (w1.load_done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_single_pulse: got %b, required 0", w1.load_done);
        end
        w1.rd_en = 1'b1;
        w1.rd_addr = 4'd1;
        tick();
        w1.rd_en = 1'b0;
        n_tests++;
        if (w1.wmem_valid !== 1'b1 || w1.wmem_out !== ref_read(1)) begin
            n_fail++;
            $display("FAIL read_addr1: got vld=%b out=%h, required vld=1 out=%h", w1.wmem_valid, w1.wmem_out, ref_read(1));
        end
        tick();
        n_tests++;
        if (w1.wmem_valid !== 1'b0 || w1.wmem_out !== ref_read(1)) begin
            n_fail++;
            $display("FAIL read_hold: got vld=%b out=%h, required vld=0 out=%h", w1.wmem_valid, w1.wmem_out, ref_read(1));
        end
        for (int a = 0; a < DEPTH; a++) begin
            w1.rd_en = 1'b1;
            w1.rd_addr = ABW'(a);
            tick();
            n_tests++;
            if (w1.wmem_valid !== 1'b1 || w1.wmem_out !== ref_read(a)) begin
                n_fail++;
                $display("FAIL back_to_back_read a=%0d: got vld=%b out=%h, required vld=1 out=%h",
                         a, w1.wmem_valid, w1.wmem_out, ref_read(a));
            end
        end
        w1.rd_en = 1'b0;
        tick();
    endtask

    task automatic test_backpressure;
        int hs;
        int lag;
        bit trf;
        bit issue;
        int a;
        logic [OW-1:0] last_exp;
        run_load(1, NB, 1'b1, hs, trf, lag);
        n_tests++;
        if (hs != NB || lag != 0) begin
            n_fail++;
            $display("FAIL gapped_load_done: got handshakes=%0d lag=%0d, required %0d and 0", hs, lag, NB);
        end
        w1.rd_en = 1'b1;
        w1.rd_addr = 4'd3;
        tick();
        w1.rd_en = 1'b0;
        last_exp = ref_read(3);
        n_tests++;
        if (w1.wmem_valid !== 1'b1 || w1.wmem_out !== last_exp) begin
            n_fail++;
            $display("FAIL gapped_read_addr3: got vld=%b out=%h, required vld=1 out=%h", w1.wmem_valid, w1.wmem_out, last_exp);
        end
        run_load(2, NB, 1'b0, hs, trf, lag);
        n_tests++;
        if (hs != NB || lag != 0) begin
            n_fail++;
            $display("FAIL random_load_done: got handshakes=%0d lag=%0d, required %0d and 0", hs, lag, NB);
        end
        for (int c = 0; c < 16; c++) begin
            issue = 1'($urandom_range(0, 1));
            a = int'($urandom_range(0, DEPTH - 1));
            w1.rd_en = issue;
            w1.rd_addr = ABW'(a);
            tick();
            if (issue) last_exp = ref_read(a);
            n_tests++;
            if (w1.wmem_valid !== issue || w1.wmem_out !== last_exp) begin
                n_fail++;
                $display("FAIL random_read c=%0d: got vld=%b out=%h, required vld=%b out=%h",
                         c, w1.wmem_valid, w1.wmem_out, issue, last_exp);
            end
        end
        w1.rd_en = 1'b0;
        tick();
    endtask

    task automatic test_ignored_writes;
        for (int c = 0; c < 4; c++) begin
            w1.s_wload_tvalid = 1'b1;
            w1.s_wload_tdata = W'($urandom);
            tick();
            n_tests++;
            if (w1.s_wload_tready !== 1'b0) begin
                n_fail++;
                $display("FAIL tready_in_ready c=%0d: got %b, required 0", c, w1.s_wload_tready);
            end
        end
        w1.s_wload_tvalid = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            w1.rd_en = 1'b1;
            w1.rd_addr = ABW'(a);
            tick();
            n_tests++;
            if (w1.wmem_out !== ref_read(a)) begin
                n_fail++;
                $display("FAIL contents_unchanged a=%0d: got %h, required %h", a, w1.wmem_out, ref_read(a));
            end
        end
        w1.rd_en = 1'b0;
        tick();
    endtask

    task automatic test_reads_blocked;
        int hs;
        int lag;
        bit trf;
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            w1.rd_en = 1'b1;
            w1.rd_addr = ABW'(c);
            w1.s_wload_tvalid = 1'b1;
            tick();
            n_tests++;
            if ({w1.wmem_valid, w1.wmem_rdy, w1.s_wload_tready} !== 3'b000) begin
                n_fail++;
                $display("FAIL blocked_in_empty c=%0d: got vld/rdy/tready=%b, required 000",
                         c, {w1.wmem_valid, w1.wmem_rdy, w1.s_wload_tready});
            end
        end
        idle_inputs();
        run_load(0, 4, 1'b0, hs, trf, lag);
        for (int c = 0; c < 3; c++) begin
            w1.rd_en = 1'b1;
            w1.rd_addr = ABW'(c);
            tick();
            n_tests++;
            if ({w1.wmem_valid, w1.wmem_rdy, w1.s_wload_tready} !== 3'b001) begin
                n_fail++;
                $display("FAIL blocked_in_load c=%0d: got vld/rdy/tready=%b, required 001",
                         c, {w1.wmem_valid, w1.wmem_rdy, w1.s_wload_tready});
            end
        end
        idle_inputs();
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        tick();
    endtask

    task automatic test_out_of_range;
        int hs;
        int lag;
        bit trf;
        int a;
        run_load(2, NB, 1'b0, hs, trf, lag);
        n_tests++;
        if (hs != NB || lag != 0) begin
            n_fail++;
            $display("FAIL oor_load_done: got handshakes=%0d lag=%0d, required %0d and 0", hs, lag, NB);
        end
        for (int c = 0; c < 5; c++) begin
            a = (c == 0) ? 5 : int'($urandom_range(DEPTH, (1 << ABW) - 1));
            w1.rd_en = 1'b1;
            w1.rd_addr = ABW'(a);
            tick();
            n_tests++;
            if (w1.wmem_valid !== 1'b1 || w1.wmem_out !== '0) begin
                n_fail++;
                $display("FAIL out_of_range a=%0d: got vld=%b out=%h, required vld=1 out=0", a, w1.wmem_valid, w1.wmem_out);
            end
        end
        w1.rd_addr = 4'd2;
        tick();
        w1.rd_en = 1'b0;
        n_tests++;
        if (w1.wmem_out !== ref_read(2)) begin
            n_fail++;
            $display("FAIL in_range_after_oor: got %h, required %h", w1.wmem_out, ref_read(2));
        end
        tick();
    endtask

    task automatic test_overlap;
        int hs;
        int lag;
        bit trf;
        logic [OW-1:0] exp_old;
        exp_old = ref_read(0);
        w1.load_start = 1'b1;
        w1.rd_en = 1'b1;
        w1.rd_addr = 4'd0;
        tick();
        idle_inputs();
        n_tests++;
        if (w1.wmem_valid !== 1'b1 || w1.wmem_out !== exp_old) begin
            n_fail++;
            $display("FAIL overlap_read: got vld=%b out=%h, required vld=1 out=%h", w1.wmem_valid, w1.wmem_out, exp_old);
        end
        n_tests++;
        if ({w1.s_wload_tready, w1.wmem_rdy} !== 2'b10) begin
            n_fail++;
            $display("FAIL overlap_to_load: got tready/rdy=%b, required 10", {w1.s_wload_tready, w1.wmem_rdy});
        end
        run_load(2, NB, 1'b0, hs, trf, lag);
        n_tests++;
        if (hs != NB || lag != 0) begin
            n_fail++;
            $display("FAIL overlap_reload_done: got handshakes=%0d lag=%0d, required %0d and 0", hs, lag, NB);
        end
        for (int a = 0; a < DEPTH; a++) begin
            w1.rd_en = 1'b1;
            w1.rd_addr = ABW'(a);
            tick();
            n_tests++;
            if (w1.wmem_valid !== 1'b1 || w1.wmem_out !== ref_read(a)) begin
                n_fail++;
                $display("FAIL reload_contents a=%0d: got vld=%b out=%h, required vld=1 out=%h",
                         a, w1.wmem_valid, w1.wmem_out, ref_read(a));
            end
        end
        w1.rd_en = 1'b0;
        tick();
    endtask

    task automatic test_midload_reset_lat2;
        int hs;
        int lag;
        bit trf;
        run_load(0, 3, 1'b0, hs, trf, lag);
        aresetn = 1'b0;
        tick();
        n_tests++;
        if ({w1.wmem_out, w1.wmem_valid, w1.wmem_rdy, w1.load_done, w1.s_wload_tready} !== '0 ||
            {w2.wmem_out, w2.wmem_valid, w2.wmem_rdy, w2.load_done, w2.s_wload_tready} !== '0) begin
            n_fail++;
            $display("FAIL midload_reset: got out1=%h tready1=%b out2=%h tready2=%b, required all zero",
                     w1.wmem_out, w1.s_wload_tready, w2.wmem_out, w2.s_wload_tready);
        end
        aresetn = 1'b1;
        w1.rd_en = 1'b1;
        tick();
        tick();
        w1.rd_en = 1'b0;
        n_tests++;
        if ({w1.wmem_valid, w2.wmem_valid, w1.wmem_rdy, w1.s_wload_tready} !== 4'b0000) begin
            n_fail++;
            $display("FAIL empty_after_midload_reset: got vld1/vld2/rdy/tready=%b, required 0000",
                     {w1.wmem_valid, w2.wmem_valid, w1.wmem_rdy, w1.s_wload_tready});
        end
        run_load(0, NB, 1'b0, hs, trf, lag);
        n_tests++;
        if (hs != NB || lag != 0 || w2.wmem_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL reload_after_reset: got handshakes=%0d lag=%0d rdy2=%b, required %0d, 0, 1",
                     hs, lag, w2.wmem_rdy, NB);
        end
        w1.rd_en = 1'b1;
        w1.rd_addr = 4'd2;
        tick();
        w1.rd_en = 1'b0;
        n_tests++;
        if (w2.wmem_valid !== 1'b0 || w1.wmem_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL lat2_not_early: got vld2=%b vld1=%b, required 0 and 1", w2.wmem_valid, w1.wmem_valid);
        end
        tick();
        n_tests++;
        if (w2.wmem_valid !== 1'b1 || w2.wmem_out !== ref_read(2)) begin
            n_fail++;
            $display("FAIL lat2_read_addr2: got vld=%b out=%h, required vld=1 out=%h", w2.wmem_valid, w2.wmem_out, ref_read(2));
        end
        tick();
        n_tests++;
        if (w2.wmem_valid !== 1'b0 || w2.wmem_out !== ref_read(2)) begin
            n_fail++;
            $display("FAIL lat2_hold: got vld=%b out=%h, required vld=0 out=%h", w2.wmem_valid, w2.wmem_out, ref_read(2));
        end
        for (int c = 0; c < DEPTH + 2; c++) begin
            w1.rd_en = (c < DEPTH);
            w1.rd_addr = ABW'(c % DEPTH);
            tick();
            if (c >= 1 && c <= DEPTH) begin
                n_tests++;
                if (w2.wmem_valid !== 1'b1 || w2.wmem_out !== ref_read(c - 1)) begin
                    n_fail++;
                    $display("FAIL lat2_back_to_back c=%0d: got vld=%b out=%h, required vld=1 out=%h",
                             c, w2.wmem_valid, w2.wmem_out, ref_read(c - 1));
                end
            end else begin
                n_tests++;
                if (w2.wmem_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL lat2_idle c=%0d: got vld=%b, required 0", c, w2.wmem_valid);
                end
            end
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_full_load();
        test_backpressure();
        test_ignored_writes();
        test_reads_blocked();
        test_out_of_range();
        test_overlap();
        test_midload_reset_lat2();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion within time limit, required bench to finish");
        $fatal(1);
    end
endmodule
